// File: rtl/change_dispenser.sv
// change_dispenser
//
// Computes the change (or full refund) for a vending transaction and pays it
// out one coin at a time to the coin ejector over a valid/ready handshake.
// Coins are picked greedily from three denominations (HI, MID, LO), and each
// denomination has its own inventory counter. Whatever cannot be paid from
// the available inventory is reported as a shortfall.
//
// Optional build macro: CHANGE_TIMEOUT_EN
//   When defined, a coin left waiting for TIMEOUT_CYC cycles without being
//   accepted is withdrawn. The transaction then ends with timeout_flag set.
//   When undefined, a presented coin waits forever and timeout_flag is 0.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start              one-cycle request, sampled only while idle
//   current_amount     inserted credit, latched with start
//   product_price      selected price, latched with start (0 = cancel)
//   refill             reload every inventory to INV_INIT, honoured only while idle
//   coin_ready         ejector accepts the presented coin
//   coin_valid         a coin is being presented
//   coin_sel           presented coin type: 2 = HI, 1 = MID, 0 = LO
//   busy               high whenever a transaction is in progress
//   done               one-cycle completion pulse
//   valid_transaction  1 = sale, 0 = refund
//   change_amount      total owed for the current/last transaction
//   shortfall          amount that could not be paid out
//   inv_flat           inventory counts {HI, MID, LO}
//   timeout_flag       handshake timed out
module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int VAL_HI      = 10,
    parameter int VAL_MID     = 5,
    parameter int VAL_LO      = 1,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AMT_W-1:0]   current_amount,
    input  logic [AMT_W-1:0]   product_price,
    input  logic               refill,
    input  logic               coin_ready,
    output logic               coin_valid,
    output logic [1:0]         coin_sel,
    output logic               busy,
    output logic               done,
    output logic               valid_transaction,
    output logic [AMT_W-1:0]   change_amount,
    output logic [AMT_W-1:0]   shortfall,
    output logic [3*INV_W-1:0] inv_flat,
    output logic               timeout_flag
);

    localparam logic [AMT_W-1:0] V_HI     = AMT_W'(VAL_HI);
    localparam logic [AMT_W-1:0] V_MID    = AMT_W'(VAL_MID);
    localparam logic [AMT_W-1:0] V_LO     = AMT_W'(VAL_LO);
    localparam logic [INV_W-1:0] INV_FULL = INV_W'(INV_INIT);
    localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] amt_lat;
    logic [AMT_W-1:0] price_lat;
    logic [AMT_W-1:0] remain;
    logic [INV_W-1:0] inv_hi;
    logic [INV_W-1:0] inv_mid;
    logic [INV_W-1:0] inv_lo;

    logic             sel_found;
    logic [1:0]       sel_coin;

`ifdef CHANGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_flag;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Face value of a coin type.
    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd2:    coin_value = V_HI;
            2'd1:    coin_value = V_MID;
            default: coin_value = V_LO;
        endcase
    endfunction

    // Greedy choice: the largest coin that still fits in the remainder and
    // that is still in stock.
    always_comb begin
        sel_found = 1'b0;
        sel_coin  = 2'd0;
        if (remain != '0) begin
            if (remain >= V_HI && inv_hi != '0) begin
                sel_found = 1'b1;
                sel_coin  = 2'd2;
            end else if (remain >= V_MID && inv_mid != '0) begin
                sel_found = 1'b1;
                sel_coin  = 2'd1;
            end else if (remain >= V_LO && inv_lo != '0) begin
                sel_found = 1'b1;
                sel_coin  = 2'd0;
            end
        end
    end

    assign inv_flat = {inv_hi, inv_mid, inv_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            amt_lat           <= '0;
            price_lat         <= '0;
            remain            <= '0;
            inv_hi            <= INV_FULL;
            inv_mid           <= INV_FULL;
            inv_lo            <= INV_FULL;
            coin_valid        <= 1'b0;
            coin_sel          <= 2'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            valid_transaction <= 1'b0;
            change_amount     <= '0;
            shortfall         <= '0;
`ifdef CHANGE_TIMEOUT_EN
            to_cnt            <= '0;
            to_flag           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Refill is applied on the same edge as start, so the
                    // new transaction already sees full inventory.
                    if (refill) begin
                        inv_hi  <= INV_FULL;
                        inv_mid <= INV_FULL;
                        inv_lo  <= INV_FULL;
                    end
                    if (start) begin
                        amt_lat   <= current_amount;
                        price_lat <= product_price;
                        busy      <= 1'b1;
                        state     <= S_CALC;
`ifdef CHANGE_TIMEOUT_EN
                        to_flag   <= 1'b0;
                        to_cnt    <= '0;
`endif
                    end
                end

                S_CALC: begin
                    // The subtraction is only taken when amount >= price, so
                    // it cannot wrap.
                    if (price_lat != '0 && amt_lat >= price_lat) begin
                        change_amount     <= amt_lat - price_lat;
                        remain            <= amt_lat - price_lat;
                        valid_transaction <= 1'b1;
                    end else begin
                        change_amount     <= amt_lat;
                        remain            <= amt_lat;
                        valid_transaction <= 1'b0;
                    end
                    state <= S_DISPENSE;
                end

                S_DISPENSE: begin
                    if (coin_valid) begin
                        if (coin_ready) begin
                            // Coin accepted: charge it against the remainder
                            // and the stock. The next coin is chosen one
                            // cycle later from the updated values.
                            coin_valid <= 1'b0;
                            remain     <= remain - coin_value(coin_sel);
                            case (coin_sel)
                                2'd2:    if (inv_hi  != '0) inv_hi  <= inv_hi  - INV_ONE;
                                2'd1:    if (inv_mid != '0) inv_mid <= inv_mid - INV_ONE;
                                default: if (inv_lo  != '0) inv_lo  <= inv_lo  - INV_ONE;
                            endcase
`ifdef CHANGE_TIMEOUT_EN
                            to_cnt <= '0;
                        end else if (to_cnt == TO_LAST) begin
                            // Give up on the ejector; the pending coin is
                            // not deducted.
                            coin_valid <= 1'b0;
                            to_flag    <= 1'b1;
                            to_cnt     <= '0;
                            state      <= S_DONE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
`endif
                        end
                    end else if (!sel_found) begin
                        state <= S_DONE;
                    end else begin
                        coin_valid <= 1'b1;
                        coin_sel   <= sel_coin;
                    end
                end

                S_DONE: begin
                    shortfall <= remain;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    assign timeout_flag = to_flag;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule
